alarm_bank: RTL and testbench
=============================

# alarm_bank

Multi-channel successor to the watch controller's single alarm: stores `NUM_ALARMS` independently enabled BCD alarm times, compares them against the running watch time on each minute tick, and drives a ring state machine with snooze, auto-timeout and dismiss. Sits beside the time-keeping counters in the watch controller. It takes the current HH:MM digits plus minute/second tick pulses, and feeds the buzzer and display mux.

## Interface
- `SEL_W`, 2: channel select width; `NUM_ALARMS = 2**SEL_W` (1..16 channels).
- `RING_SECS`, 60: `secTick` pulses an alarm rings before auto-stop (1..255).
- `SNOOZE_MIN`, 5: snooze interval in minutes (1..59).
- `MAX_SNOOZE`, 3: snoozes allowed per ring event (0..15).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `curHour1`, `curHour0`, `curMin1`, `curMin0`  in  4 each  current time, BCD; already updated on the cycle `minTick` is high.
- `minTick`  in  1  one-cycle pulse per minute rollover.
- `secTick`  in  1  one-cycle pulse per second.
- `sel`  in  `SEL_W`  channel for write and display.
- `wrEn`  in  1  write `wrHour1`/`wrHour0`/`wrMin1`/`wrMin0` and `wrArm` into channel `sel`.
- `wrHour1`, `wrHour0`, `wrMin1`, `wrMin0`  in  4 each  alarm time to store, BCD.
- `wrArm`  in  1  enable bit stored with the write.
- `snooze`  in  1  snooze request, level sampled per cycle.
- `dismiss`  in  1  stop request, level sampled per cycle.
- `alarm`  out  1  ringing.
- `snoozing`  out  1  snooze pending.
- `ringId`  out  `SEL_W`  channel that caused the current ring/snooze.
- `disH1`, `disH0`, `disM1`, `disM0`  out  4 each  stored time of channel `sel`.
- `disArm`  out  1  enable bit of channel `sel`.

## Operation
- Per channel: registers H1, H0, M1, M0 and arm. Reset clears all to 00:00, disarmed.
- Write validation:
  - `wrEn` stores the write only if it is valid BCD with hour ≤ 23 and minute ≤ 59.
  - An invalid write is dropped entirely, leaving the channel unchanged.
- Match:
  - Evaluated only on cycles with `minTick`=1 and state IDLE.
  - A channel matches when it is armed and all four digits equal the current time.
  - If several channels match, the lowest index wins; other matches that minute are lost.
  - Matches during RING or SNOOZE are ignored.
- State IDLE: `alarm`=0, `snoozing`=0. A match moves to RING, latches `ringId`, clears the ring-second counter and clears the snooze count.
- State RING: `alarm`=1.
  - Each `secTick` increments the ring counter.
  - `dismiss` moves to IDLE.
  - `snooze` moves to SNOOZE if snooze count < `MAX_SNOOZE`. It then increments the count and latches target = current time + `SNOOZE_MIN`. Otherwise `snooze` is ignored.
  - Reaching `RING_SECS` ticks moves to IDLE (auto-timeout, treated as dismiss).
- State SNOOZE: `snoozing`=1, `alarm`=0.
  - `dismiss` moves to IDLE.
  - `minTick` with current time equal to target moves to RING with the same `ringId`, clears the ring counter and keeps the snooze count.
- Snooze target arithmetic (BCD):
  - Add `SNOOZE_MIN` to minutes; if the result is ≥ 60, subtract 60 and carry 1 to the hour.
  - Hour wraps 23 → 00. Example: 23:58 + 5 = 00:03.
- Simultaneous events:
  - `reset` beats everything.
  - `dismiss` beats `snooze`.
  - `dismiss`/`snooze` beat auto-timeout on the same cycle.
  - If `wrEn` and `minTick` occur in the same cycle, the match uses the pre-write stored values.
  - Writing, or disarming, the ringing channel does not stop a ring or snooze in progress.
- Display: `dis*`/`disArm` are registered copies of channel `sel`, updated every cycle, including during a write.

## Timing
- Reset values: `alarm`=0, `snoozing`=0, `ringId`=0, `dis*`=0, `disArm`=0, state IDLE, all counters 0.
- `alarm` rises on the cycle after the matching `minTick` edge.
- `alarm` falls on the cycle after the `dismiss`/`snooze` sample edge, or after the edge with the `RING_SECS`-th `secTick`.
- Snooze-return ring: `alarm` rises on the cycle after the `minTick` carrying the target time.
- Display latency: 1 cycle from `sel` or write to `dis*`.
- Written alarm data is usable for matching from the cycle after `wrEn`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then write ch2 = 07:30 armed; drive 07:29 → 07:30 with `minTick` → `alarm`=1 one cycle later, `ringId`=2. Then `dismiss` → `alarm`=0 next cycle.
- Arm ch1 and ch3 both at 12:00; tick to 12:00 → `ringId`=1 only. Ch3 does not ring after ch1 is dismissed in the same minute.
- Ring at 23:58, `snooze` → `snoozing`=1. Tick to 00:02 → no ring; tick to 00:03 → `alarm`=1, same `ringId`.
- With `MAX_SNOOZE`=3, snooze three times → the fourth `snooze` is ignored and `alarm` stays 1. Then 60 `secTick` → `alarm`=0 on the cycle after the 60th.
- Write 24:00 or 12:60 to ch0 → `dis*` still shows the previous value. `dismiss`+`snooze` in the same cycle while ringing → IDLE, `snoozing`=0.
- Assert `reset` mid-RING → next cycle `alarm`=0, `ringId`=0, all channels disarmed at 00:00; a subsequent 00:00 `minTick` → no ring.

Source files
------------

// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS-channel BCD alarm store with ring/snooze/auto-timeout FSM; ports: clk/reset, current time + minTick/secTick, channel write (sel/wrEn/wr*), snooze/dismiss, alarm/snoozing/ringId status, dis* readback of channel sel
module alarm_bank #(
  parameter int SEL_W      = 2,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       curHour1,
  input  logic [3:0]       curHour0,
  input  logic [3:0]       curMin1,
  input  logic [3:0]       curMin0,
  input  logic             minTick,
  input  logic             secTick,
  input  logic [SEL_W-1:0] sel,
  input  logic             wrEn,
  input  logic [3:0]       wrHour1,
  input  logic [3:0]       wrHour0,
  input  logic [3:0]       wrMin1,
  input  logic [3:0]       wrMin0,
  input  logic             wrArm,
  input  logic             snooze,
  input  logic             dismiss,
  output logic             alarm,
  output logic             snoozing,
  output logic [SEL_W-1:0] ringId,
  output logic [3:0]       disH1,
  output logic [3:0]       disH0,
  output logic [3:0]       disM1,
  output logic [3:0]       disM0,
  output logic             disArm
);
  localparam int N = 2**SEL_W;
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t           state_q, state_d;
  logic [16:0]      ch_q [N];
  logic [16:0]      ch_d [N];
  logic [16:0]      dis_q, dis_d;
  logic [SEL_W-1:0] ring_id_q, ring_id_d;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic [3:0]       snz_cnt_q, snz_cnt_d;
  logic [15:0]      tgt_q, tgt_d;
  logic [15:0]      cur, wr_time, snz_tgt;
  logic             wr_ok, hit, m_carry;
  logic [SEL_W-1:0] hit_id;
  logic [6:0]       m_sum, m_adj;
  logic [4:0]       h_sum, h_adj;
  assign cur     = {curHour1, curHour0, curMin1, curMin0};
  assign wr_time = {wrHour1, wrHour0, wrMin1, wrMin0};
  assign wr_ok   = wrEn && wrHour1 <= 4'd2 && wrHour0 <= 4'd9 && (wrHour1 != 4'd2 || wrHour0 <= 4'd3)
                   && wrMin1 <= 4'd5 && wrMin0 <= 4'd9;
  // display bypasses the write so the new value appears one cycle after wrEn
  assign dis_d   = wr_ok ? {wrArm, wr_time} : ch_q[sel];
  assign m_sum   = 7'(curMin1) * 7'd10 + 7'(curMin0) + 7'(SNOOZE_MIN);
  assign m_carry = m_sum >= 7'd60;
  assign m_adj   = m_carry ? m_sum - 7'd60 : m_sum;
  assign h_sum   = 5'(curHour1) * 5'd10 + 5'(curHour0) + 5'(m_carry);
  assign h_adj   = h_sum >= 5'd24 ? h_sum - 5'd24 : h_sum;
  assign snz_tgt = {4'(h_adj / 5'd10), 4'(h_adj % 5'd10), 4'(m_adj / 7'd10), 4'(m_adj % 7'd10)};
  always_comb begin
    ch_d = ch_q;
    if (wr_ok) ch_d[sel] = {wrArm, wr_time};
  end
  // scan high to low so the lowest matching channel wins
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (ch_q[i][16] && ch_q[i][15:0] == cur) begin
        hit    = 1'b1;
        hit_id = SEL_W'(i);
      end
  end
  always_comb begin
    state_d    = state_q;
    ring_id_d  = ring_id_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    tgt_d      = tgt_q;
    case (state_q)
      IDLE:
        if (minTick && hit) begin
          state_d    = RING;
          ring_id_d  = hit_id;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
        end
      RING:
        if (dismiss) state_d = IDLE;
        else if (snooze && snz_cnt_q < 4'(MAX_SNOOZE)) begin
          state_d   = SNOOZE;
          snz_cnt_d = snz_cnt_q + 4'd1;
          tgt_d     = snz_tgt;
        end else if (secTick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_q == 8'(RING_SECS - 1)) state_d = IDLE;
        end
      SNOOZE:
        if (dismiss) state_d = IDLE;
        else if (minTick && cur == tgt_q) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= '{default: '0};
      dis_q      <= '0;
      ring_id_q  <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      tgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      dis_q      <= dis_d;
      ring_id_q  <= ring_id_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tgt_q      <= tgt_d;
    end
  end
  assign alarm    = state_q == RING;
  assign snoozing = state_q == SNOOZE;
  assign ringId   = ring_id_q;
  assign {disArm, disH1, disH0, disM1, disM0} = dis_q;
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: scoreboard bench for alarm_bank ring, tie-break, snooze, timeout, write validation and reset
module tb_alarm_bank;
  logic       clk = 1'b0;
  logic       reset, minTick, secTick, wrEn, wrArm, snooze, dismiss;
  logic [3:0] curHour1, curHour0, curMin1, curMin0;
  logic [3:0] wrHour1, wrHour0, wrMin1, wrMin0;
  logic [1:0] sel, ringId;
  logic       alarm, snoozing, disArm;
  logic [3:0] disH1, disH0, disM1, disM0;
  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic        dchk;
    logic [16:0] dis;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_err = 0;
  alarm_bank #(.SEL_W(2), .RING_SECS(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .clk(clk), .reset(reset),
    .curHour1(curHour1), .curHour0(curHour0), .curMin1(curMin1), .curMin0(curMin0),
    .minTick(minTick), .secTick(secTick), .sel(sel), .wrEn(wrEn),
    .wrHour1(wrHour1), .wrHour0(wrHour0), .wrMin1(wrMin1), .wrMin0(wrMin0), .wrArm(wrArm),
    .snooze(snooze), .dismiss(dismiss), .alarm(alarm), .snoozing(snoozing), .ringId(ringId),
    .disH1(disH1), .disH0(disH0), .disM1(disM1), .disM0(disM0), .disArm(disArm)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] st_of(input logic a, input logic s, input logic [1:0] id);
    return {a, s, id};
  endfunction
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 17'({alarm, snoozing, ringId}), 17'(e.st));
      if (e.dchk) check({e.tag, "_dis"}, {disArm, disH1, disH0, disM1, disM0}, e.dis);
    end
  end
  task automatic step(input string tag, input logic [3:0] st, input logic dchk = 1'b0,
                      input logic [16:0] dis = '0);
    exp_t x;
    x.tag  = tag;
    x.st   = st;
    x.dchk = dchk;
    x.dis  = dis;
    sb.push_back(x);
    @(negedge clk);
    {reset, minTick, secTick, snooze, dismiss, wrEn} = '0;
  endtask
  task automatic tm(input logic [15:0] t);
    {curHour1, curHour0, curMin1, curMin0} = t;
    minTick = 1'b1;
  endtask
  task automatic wr(input logic [1:0] ch, input logic [15:0] t, input logic a);
    sel = ch;
    {wrHour1, wrHour0, wrMin1, wrMin0} = t;
    wrArm = a;
    wrEn  = 1'b1;
  endtask
  initial begin
    {minTick, secTick, snooze, dismiss, wrEn, wrArm, sel} = '0;
    {curHour1, curHour0, curMin1, curMin0, wrHour1, wrHour0, wrMin1, wrMin0} = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step("reset", st_of(0, 0, 0), 1'b1, 17'h0);
    wr(2, 16'h0730, 1);    step("wr_ch2", st_of(0, 0, 0), 1'b1, {1'b1, 16'h0730});
    tm(16'h0729);          step("pre_match", st_of(0, 0, 0));
    tm(16'h0730);          step("ring_ch2", st_of(1, 0, 2));
    step("hold_ring", st_of(1, 0, 2));
    dismiss = 1'b1;        step("dismiss_ch2", st_of(0, 0, 2));
    wr(1, 16'h1200, 1);    step("wr_ch1", st_of(0, 0, 2), 1'b1, {1'b1, 16'h1200});
    wr(3, 16'h1200, 1);    step("wr_ch3", st_of(0, 0, 2), 1'b1, {1'b1, 16'h1200});
    tm(16'h1159);          step("pre_tie", st_of(0, 0, 2));
    tm(16'h1200);          step("tie_low_wins", st_of(1, 0, 1));
    dismiss = 1'b1;        step("dismiss_ch1", st_of(0, 0, 1));
    step("ch3_lost", st_of(0, 0, 1));
    tm(16'h1201);          step("next_min_quiet", st_of(0, 0, 1));
    wr(0, 16'h2358, 1);    step("wr_ch0", st_of(0, 0, 1), 1'b1, {1'b1, 16'h2358});
    tm(16'h2357);          step("pre_midnight", st_of(0, 0, 1));
    tm(16'h2358);          step("ring_ch0", st_of(1, 0, 0));
    snooze = 1'b1;         step("snooze1", st_of(0, 1, 0));
    tm(16'h2359);          step("snz_2359", st_of(0, 1, 0));
    tm(16'h0000);          step("snz_0000", st_of(0, 1, 0));
    tm(16'h0001);          step("snz_0001", st_of(0, 1, 0));
    tm(16'h0002);          step("snz_0002", st_of(0, 1, 0));
    tm(16'h0003);          step("rering_0003", st_of(1, 0, 0));
    snooze = 1'b1;         step("snooze2", st_of(0, 1, 0));
    tm(16'h0007);          step("snz_0007", st_of(0, 1, 0));
    tm(16'h0008);          step("rering_0008", st_of(1, 0, 0));
    snooze = 1'b1;         step("snooze3", st_of(0, 1, 0));
    tm(16'h0013);          step("rering_0013", st_of(1, 0, 0));
    snooze = 1'b1;         step("snooze4_ignored", st_of(1, 0, 0));
    for (int i = 1; i <= 60; i++) begin
      secTick = 1'b1;
      step($sformatf("sec%0d", i), i == 60 ? st_of(0, 0, 0) : st_of(1, 0, 0));
    end
    wr(0, 16'h2400, 1);    step("bad_hour", st_of(0, 0, 0), 1'b1, {1'b1, 16'h2358});
    wr(0, 16'h1260, 0);    step("bad_min", st_of(0, 0, 0), 1'b1, {1'b1, 16'h2358});
    tm(16'h2358);          step("ring_again", st_of(1, 0, 0));
    dismiss = 1'b1;
    snooze  = 1'b1;        step("dismiss_beats_snooze", st_of(0, 0, 0));
    step("stay_idle", st_of(0, 0, 0));
    tm(16'h1200);          step("ring_ch1", st_of(1, 0, 1));
    reset = 1'b1;
    sel   = 1;             step("reset_mid_ring", st_of(0, 0, 0), 1'b1, 17'h0);
    step("ch1_cleared", st_of(0, 0, 0), 1'b1, 17'h0);
    sel = 0;               step("ch0_cleared", st_of(0, 0, 0), 1'b1, 17'h0);
    tm(16'h0000);          step("no_ring_0000", st_of(0, 0, 0));
    repeat (2) @(negedge clk);
    check("sb_drained", 17'(sb.size()), 17'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
